page_reader: RTL and testbench

- I2C master that reads one 64-byte page from the 24LC256-class serial EEPROM into a 512-bit buffer.
- It is the read-side counterpart of the page writer and shares the same sdata/sclk bus and address format.
- It is used by the dump/readback path to recover logged ADC samples.
- Byte order matches the logging path: the first byte read lands in read_data[511:504] and the last in read_data[7:0].

---
 rtl/page_reader_if.sv | 23 ++
 rtl/page_reader.sv | 155 +++++++++++++++
 tb/tb_page_reader.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/page_reader_if.sv
// page_reader_if: host and I2C signal bundle between page_reader and the host/EEPROM side.
interface page_reader_if #(
    parameter int PAGE_BYTES = 64
);
    logic                    enable;
    logic [14:0]             address;
    logic                    sclk;
    logic                    sda_m_oe;
    logic                    sda_s_oe;
    logic                    sda_in;
    wire                     sdata;
    logic [8*PAGE_BYTES-1:0] read_data;
    logic                    busy;
    logic                    done;
    logic                    ack_error;
    // open-drain line: reads high unless either side pulls it low
    assign sdata  = (sda_m_oe || sda_s_oe) ? 1'b0 : 1'bz;
    assign sda_in = !(sda_m_oe || sda_s_oe);
    modport master (input enable, address, sda_in,
                    output sclk, sda_m_oe, read_data, busy, done, ack_error);
    modport slave  (output enable, address, sda_s_oe,
                    input sclk, sdata, sda_in, read_data, busy, done, ack_error);
endinterface

// File: rtl/page_reader.sv
// page_reader: I2C master reading one PAGE_BYTES page from a 24LC256-class EEPROM.
module page_reader #(
    parameter int         CLK_DIV    = 125,
    parameter logic [2:0] DEV_ADDR   = 3'b000,
    parameter int         PAGE_BYTES = 64
) (
    input  logic          clk,
    input  logic          rst,
    page_reader_if.master bus
);
    localparam int W  = 8 * PAGE_BYTES;
    localparam int DW = $clog2(CLK_DIV);
    localparam int RW = $clog2(PAGE_BYTES + 1);
    typedef enum logic [3:0] {
        IDLE, START, SEND_BYTE, GET_ACK, RSTART, READ_BYTE, SEND_ACK, STOP, DONE
    } state_t;
    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic [RW-1:0] r_rcnt;
    logic [14:0]   r_addr;
    logic [7:0]    r_tx;
    logic [W-1:0]  r_shadow;
    logic [W-1:0]  r_read_data;
    logic          r_sclk;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_done;
    logic          r_ack_error;
    logic          r_nack;
    logic          w_tick;
    logic          w_end;
    logic          w_last;
    logic          w_scl;
    logic          w_oe;
    assign w_tick = r_div == DW'(CLK_DIV - 1);
    assign w_end  = w_tick && r_q == 2'd3;
    assign w_last = r_rcnt == RW'(PAGE_BYTES - 1);
    // line levels per quarter; outputs are registered one clock behind the phase
    always_comb begin
        w_scl = r_q == 2'd1 || r_q == 2'd2;
        w_oe  = 1'b0;
        case (r_state)
            IDLE, DONE: w_scl = 1'b1;
            START: begin
                w_scl = r_q != 2'd3;
                w_oe  = r_q[1];
            end
            SEND_BYTE: w_oe = !r_tx[7];
            RSTART:    w_oe = r_q[1];
            SEND_ACK:  w_oe = !w_last;
            STOP: begin
                w_scl = r_q != 2'd0;
                w_oe  = r_q != 2'd3;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_q         <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_rcnt      <= '0;
            r_addr      <= '0;
            r_tx        <= '0;
            r_shadow    <= '0;
            r_read_data <= '0;
            r_sclk      <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_sclk   <= w_scl;
            r_sda_oe <= w_oe;
            r_done   <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.enable) begin
                    r_addr      <= bus.address;
                    r_busy      <= 1'b1;
                    r_ack_error <= 1'b0;
                    r_state     <= START;
                    r_div       <= '0;
                    r_q         <= '0;
                    r_bit       <= '0;
                    r_byte      <= '0;
                    r_rcnt      <= '0;
                    r_tx        <= {4'b1010, DEV_ADDR, 1'b0};
                end
            end else if (r_state == DONE) begin
                r_state <= IDLE;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) r_q <= r_q + 1'b1;
                if (w_tick && r_q == 2'd2) begin
                    r_nack <= bus.sda_in;
                    if (r_state == READ_BYTE) r_shadow <= {r_shadow[W-2:0], bus.sda_in};
                end
                if (w_end) begin
                    case (r_state)
                        START: r_state <= SEND_BYTE;
                        SEND_BYTE: begin
                            r_tx  <= {r_tx[6:0], 1'b0};
                            r_bit <= r_bit + 1'b1;
                            if (r_bit == 3'd7) r_state <= GET_ACK;
                        end
                        GET_ACK: begin
                            r_byte <= r_byte + 1'b1;
                            if (r_nack) begin
                                r_ack_error <= 1'b1;
                                r_state     <= STOP;
                            end else if (r_byte == 2'd3) begin
                                r_state <= READ_BYTE;
                            end else if (r_byte == 2'd2) begin
                                r_state <= RSTART;
                                r_tx    <= {4'b1010, DEV_ADDR, 1'b1};
                            end else begin
                                r_state <= SEND_BYTE;
                                r_tx    <= r_byte == 2'd0 ? {1'b0, r_addr[14:8]} : r_addr[7:0];
                            end
                        end
                        RSTART: r_state <= SEND_BYTE;
                        READ_BYTE: begin
                            r_bit <= r_bit + 1'b1;
                            if (r_bit == 3'd7) r_state <= SEND_ACK;
                        end
                        SEND_ACK: begin
                            r_rcnt  <= r_rcnt + 1'b1;
                            r_state <= w_last ? STOP : READ_BYTE;
                        end
                        STOP: begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (!r_ack_error) r_read_data <= r_shadow;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end
    assign bus.sclk      = r_sclk;
    assign bus.sda_m_oe  = r_sda_oe;
    assign bus.read_data = r_read_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ack_error = r_ack_error;
endmodule

// File: tb/tb_page_reader.sv
// tb_page_reader: directed bench driving page_reader against a behavioural 24LC256 model.
module tb_page_reader;
    localparam int CLK_DIV = 2;
    localparam int LAT     = 2460 * CLK_DIV;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    page_reader_if #(.PAGE_BYTES(64)) bus ();
    page_reader #(.CLK_DIV(CLK_DIV), .DEV_ADDR(3'b000), .PAGE_BYTES(64)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    logic [7:0]  mem [0:32767];
    logic [8:0]  ev[$];
    logic        mack[$];
    logic [8:0]  basic_tr[$] = '{9'h100, 9'h0a0, 9'h008, 9'h000, 9'h100, 9'h0a1, 9'h101};
    logic        s_oe = 1'b0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        rd = 1'b0;
    logic [7:0]  sh = '0;
    logic [7:0]  txb = '0;
    logic [14:0] ptr = '0;
    int phase = 0;
    int bitn = 0;
    int byte_idx = 0;
    int nack_at = -1;
    assign bus.sda_s_oe = s_oe;

    // EEPROM model: samples on SCL rise, changes SDA one clock after SCL falls
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_scl <= bus.sclk;
        prev_sda <= bus.sda_in;
        if (bus.done) done_cnt <= done_cnt + 1;
        if (!rst) begin
            phase <= 0; s_oe <= 1'b0; byte_idx <= 0; rd <= 1'b0;
        end else if (prev_scl && bus.sclk && prev_sda && !bus.sda_in) begin
            ev.push_back(9'h100); phase <= 1; bitn <= 0; s_oe <= 1'b0;
        end else if (prev_scl && bus.sclk && !prev_sda && bus.sda_in) begin
            ev.push_back(9'h101); phase <= 0; s_oe <= 1'b0; byte_idx <= 0; rd <= 1'b0;
        end else if (!prev_scl && bus.sclk) begin
            if (phase == 1) begin
                sh <= {sh[6:0], bus.sda_in}; bitn <= bitn + 1;
            end else if (phase == 4) begin
                mack.push_back(!bus.sda_in);
                if (bus.sda_in) phase <= 0;
            end
        end else if (prev_scl && !bus.sclk) begin
            if (phase == 1 && bitn == 8) begin
                ev.push_back({1'b0, sh});
                byte_idx <= byte_idx + 1;
                if (byte_idx == nack_at) phase <= 0;
                else begin
                    s_oe <= 1'b1; phase <= 2;
                    if (byte_idx == 1) ptr[14:8] <= sh[6:0];
                    if (byte_idx == 2) ptr[7:0] <= sh;
                    if (byte_idx == 3) rd <= sh[0];
                end
            end else if (phase == 2) begin
                bitn <= 0;
                if (rd) begin
                    phase <= 3; txb <= mem[ptr]; s_oe <= !mem[ptr][7];
                end else begin
                    phase <= 1; s_oe <= 1'b0;
                end
            end else if (phase == 3) begin
                bitn <= bitn + 1; txb <= {txb[6:0], 1'b0};
                if (bitn == 7) begin
                    phase <= 4; s_oe <= 1'b0; ptr <= ptr + 15'd1;
                end else s_oe <= !txb[6];
            end else if (phase == 4) begin
                phase <= 3; bitn <= 0; txb <= mem[ptr]; s_oe <= !mem[ptr][7];
            end
        end
    end

    function automatic logic [511:0] page_of(input logic [14:0] a);
        logic [511:0] p;
        logic [14:0] ad;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            ad = a + 15'(i);
            p[511-8*i -: 8] = mem[ad];
        end
        return p;
    endfunction

    function automatic string tstr(input logic [8:0] q[$]);
        string s;
        s = "";
        foreach (q[i]) if (i < 20) s = {s, $sformatf("%h ", q[i])};
        return s;
    endfunction

    task automatic start_read(input logic [14:0] a, output int t0);
        @(negedge clk);
        bus.address = a;
        bus.enable  = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string name, input int t0, output int lat, output logic aerr);
        bit got;
        got = 1'b0; lat = -1; aerr = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1; lat = cyc - t0; aerr = bus.ack_error;
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s timeout got no done want done within 6000 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.enable = 1'b0; bus.address = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.sclk, bus.sda_m_oe, bus.busy, bus.done, bus.ack_error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 10000",
                     {bus.sclk, bus.sda_m_oe, bus.busy, bus.done, bus.ack_error});
        end
        checks++;
        if (bus.read_data !== '0) begin
            errors++; $display("FAIL reset_read_data got %h want 0", bus.read_data);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int t0, lat, d0;
        logic aerr;
        logic [63:0] mv;
        ev.delete(); mack.delete(); nack_at = -1; d0 = done_cnt;
        start_read(15'h0800, t0);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.busy); end
        wait_done("basic_done", t0, lat, aerr);
        checks++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            errors++; $display("FAIL basic_latency got %0d want %0d+-2", lat, LAT);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (tstr(ev) != tstr(basic_tr)) begin
            errors++; $display("FAIL basic_trace got %s want %s", tstr(ev), tstr(basic_tr));
        end
        mv = '0;
        foreach (mack[i]) if (i < 64) mv[63-i] = mack[i];
        checks++;
        if (mack.size() != 64 || mv !== 64'hffff_ffff_ffff_fffe) begin
            errors++;
            $display("FAIL basic_ack_pattern got %0d bits %h want 64 bits fffffffffffffffe", mack.size(), mv);
        end
        checks++;
        if (bus.read_data[511:504] !== 8'h00) begin
            errors++; $display("FAIL basic_first_byte got %h want 00", bus.read_data[511:504]);
        end
        checks++;
        if (bus.read_data[7:0] !== 8'h3f) begin
            errors++; $display("FAIL basic_last_byte got %h want 3f", bus.read_data[7:0]);
        end
        checks++;
        if (bus.read_data !== page_of(15'h0800)) begin
            errors++; $display("FAIL basic_page got %h want %h", bus.read_data, page_of(15'h0800));
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_addr_nack();
        int t0, lat;
        logic aerr;
        logic [8:0] exp_tr[$] = '{9'h100, 9'h0a0, 9'h008, 9'h000, 9'h101};
        ev.delete(); nack_at = 2;
        start_read(15'h0800, t0);
        wait_done("nack_done", t0, lat, aerr);
        checks++;
        if (aerr !== 1'b1) begin errors++; $display("FAIL nack_ack_error got %b want 1", aerr); end
        checks++;
        if (lat < 29 * 4 * CLK_DIV - 2 || lat > 29 * 4 * CLK_DIV + 2) begin
            errors++; $display("FAIL nack_latency got %0d want %0d+-2", lat, 29 * 4 * CLK_DIV);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (tstr(ev) != tstr(exp_tr)) begin
            errors++; $display("FAIL nack_trace got %s want %s", tstr(ev), tstr(exp_tr));
        end
        checks++;
        if (bus.read_data !== page_of(15'h0800)) begin
            errors++; $display("FAIL nack_read_data_kept got %h want %h", bus.read_data, page_of(15'h0800));
        end
        nack_at = -1;
        start_read(15'h0100, t0);
        checks++;
        if (bus.ack_error !== 1'b0) begin
            errors++; $display("FAIL nack_clear_at_start got %b want 0", bus.ack_error);
        end
        wait_done("nack_recover_done", t0, lat, aerr);
        repeat (4) @(negedge clk);
        checks++;
        if (aerr !== 1'b0 || bus.read_data !== page_of(15'h0100)) begin
            errors++;
            $display("FAIL nack_recover got err %b data %h want err 0 data %h", aerr, bus.read_data, page_of(15'h0100));
        end
    endtask

    task automatic test_enable_busy();
        int t0, lat, d0;
        logic aerr;
        ev.delete(); mack.delete(); d0 = done_cnt;
        start_read(15'h0800, t0);
        repeat (400) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bus.address = 15'h1234; bus.enable = 1'b1;
            @(negedge clk);
            bus.enable = 1'b0;
            repeat (97) @(negedge clk);
        end
        wait_done("busy_done", t0, lat, aerr);
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL busy_done_count got %0d want 1", done_cnt - d0);
        end
        checks++;
        if (tstr(ev) != tstr(basic_tr)) begin
            errors++; $display("FAIL busy_trace got %s want %s", tstr(ev), tstr(basic_tr));
        end
        checks++;
        if (bus.read_data !== page_of(15'h0800)) begin
            errors++; $display("FAIL busy_page got %h want %h", bus.read_data, page_of(15'h0800));
        end
    endtask

    task automatic test_reset_mid();
        int t0, lat;
        logic aerr;
        start_read(15'h0800, t0);
        repeat (1700) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.sclk, bus.sda_m_oe, bus.busy} !== 3'b100) begin
            errors++; $display("FAIL midreset_outputs got %b want 100", {bus.sclk, bus.sda_m_oe, bus.busy});
        end
        checks++;
        if (bus.read_data !== '0) begin
            errors++; $display("FAIL midreset_read_data got %h want 0", bus.read_data);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        ev.delete();
        start_read(15'h0400, t0);
        wait_done("midreset_done", t0, lat, aerr);
        repeat (4) @(negedge clk);
        checks++;
        if (aerr !== 1'b0 || bus.read_data !== page_of(15'h0400)) begin
            errors++;
            $display("FAIL midreset_reread got err %b data %h want err 0 data %h", aerr, bus.read_data, page_of(15'h0400));
        end
    endtask

    task automatic test_rollover();
        int t0, lat;
        logic aerr;
        logic [8:0] exp_tr[$] = '{9'h100, 9'h0a0, 9'h07f, 9'h0e0, 9'h100, 9'h0a1, 9'h101};
        ev.delete();
        start_read(15'h7fe0, t0);
        wait_done("roll_done", t0, lat, aerr);
        repeat (4) @(negedge clk);
        checks++;
        if (tstr(ev) != tstr(exp_tr)) begin
            errors++; $display("FAIL roll_trace got %s want %s", tstr(ev), tstr(exp_tr));
        end
        checks++;
        if ({bus.read_data[511:504], bus.read_data[263:256], bus.read_data[255:248], bus.read_data[7:0]} !== 32'h1e01001f) begin
            errors++;
            $display("FAIL roll_bytes got %h want 1e01001f",
                     {bus.read_data[511:504], bus.read_data[263:256], bus.read_data[255:248], bus.read_data[7:0]});
        end
        checks++;
        if (bus.read_data !== page_of(15'h7fe0)) begin
            errors++; $display("FAIL roll_page got %h want %h", bus.read_data, page_of(15'h7fe0));
        end
    endtask

    task automatic test_back_to_back();
        int t0, td, lat, d0;
        logic aerr;
        logic [8:0] exp_tr[$];
        exp_tr = basic_tr;
        foreach (basic_tr[i]) exp_tr.push_back(basic_tr[i]);
        ev.delete(); d0 = done_cnt;
        @(negedge clk);
        bus.address = 15'h0800; bus.enable = 1'b1;
        @(negedge clk);
        t0 = cyc;
        wait_done("b2b_first", t0, lat, aerr);
        td = cyc;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || cyc - td != 2) begin
            errors++; $display("FAIL b2b_restart got busy %b gap %0d want busy 1 gap 2", bus.busy, cyc - td);
        end
        bus.enable = 1'b0;
        wait_done("b2b_second", td + 2, lat, aerr);
        checks++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            errors++; $display("FAIL b2b_latency got %0d want %0d+-2", lat, LAT);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0);
        end
        checks++;
        if (tstr(ev) != tstr(exp_tr)) begin
            errors++; $display("FAIL b2b_trace got %s want %s", tstr(ev), tstr(exp_tr));
        end
        checks++;
        if (bus.read_data !== page_of(15'h0800)) begin
            errors++; $display("FAIL b2b_page got %h want %h", bus.read_data, page_of(15'h0800));
        end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 8'(a ^ ((a >> 7) & 'hfe));
        for (int i = 0; i < 64; i++) mem[16'h0800 + i] = 8'(i);
        test_reset();
        test_basic();
        test_addr_nack();
        test_enable_busy();
        test_reset_mid();
        test_rollover();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
